// File: rtl/branch_resolver_pkg.sv
// Shared types for the branch resolver: FSM states, buffer entry layout
// and the fall-through instruction size used with the predictor.
package branch_resolver_pkg;

    localparam logic [31:0] INSN_SIZE = 32'd4;

    typedef enum logic {
        ST_RUN,
        ST_FLUSH
    } br_state_e;

    typedef struct packed {
        logic        valid;
        logic [31:0] pc;
        logic        pred_taken;
        logic [31:0] pred_target;
        logic        resolved;
        logic        act_taken;
        logic [31:0] act_target;
    } br_entry_t;

endpackage

// File: rtl/branch_resolver.sv
// In-order branch retire/recovery: records predictions, takes outcomes by tag,
// retires in order, trains the predictor and redirects/flushes on mispredict.
// Ports: alloc_* (fetch record), res_* (FU outcome), update_* (predictor
// training), redirect/redirect_pc/flush (recovery), count (occupancy).
module branch_resolver
    import branch_resolver_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int TAG_W = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             alloc_valid,
    input  logic [31:0]      alloc_pc,
    input  logic             alloc_pred_taken,
    input  logic [31:0]      alloc_pred_target,
    output logic             alloc_ready,
    output logic [TAG_W-1:0] alloc_tag,
    input  logic             res_valid,
    input  logic [TAG_W-1:0] res_tag,
    input  logic             res_taken,
    input  logic [31:0]      res_target,
    output logic             update,
    output logic [31:0]      update_pc,
    output logic             update_taken,
    output logic [31:0]      update_target,
    output logic             redirect,
    output logic [31:0]      redirect_pc,
    output logic             flush,
    output logic [TAG_W:0]   count
);

    localparam logic [TAG_W:0] FULL = (TAG_W+1)'(DEPTH);

    br_entry_t        ent_q [DEPTH];
    br_entry_t        ent_d [DEPTH];
    logic [TAG_W-1:0] head_q, head_d;
    logic [TAG_W-1:0] tail_q, tail_d;
    logic [TAG_W:0]   count_q, count_d;
    br_state_e        state_q, state_d;

    logic             upd_q, upd_d;
    logic [31:0]      upd_pc_q, upd_pc_d;
    logic             upd_tk_q, upd_tk_d;
    logic [31:0]      upd_tgt_q, upd_tgt_d;
    logic             redir_q, redir_d;
    logic [31:0]      rpc_q, rpc_d;
    logic             flush_q, flush_d;

    br_entry_t        head_e;
    logic             retire;
    logic             mispredict;
    logic             alloc_fire;

    assign head_e = ent_q[head_q];
    assign retire = (state_q == ST_RUN) && head_e.valid && head_e.resolved;

    // Same direction but differing target only counts when both are taken.
    assign mispredict = (head_e.pred_taken != head_e.act_taken) ||
                        (head_e.pred_taken && head_e.act_taken &&
                         (head_e.pred_target != head_e.act_target));

    assign alloc_ready = (count_q < FULL) && (state_q == ST_RUN) &&
                         !(retire && mispredict);
    assign alloc_fire  = alloc_valid && alloc_ready;
    assign alloc_tag   = tail_q;
    assign count       = count_q;

    always_comb begin
        ent_d     = ent_q;
        head_d    = head_q;
        tail_d    = tail_q;
        count_d   = count_q;
        state_d   = state_q;
        upd_d     = 1'b0;
        upd_pc_d  = upd_pc_q;
        upd_tk_d  = upd_tk_q;
        upd_tgt_d = upd_tgt_q;
        redir_d   = 1'b0;
        rpc_d     = rpc_q;
        flush_d   = 1'b0;

        unique case (state_q)
            ST_RUN: begin
                if (res_valid && ent_q[res_tag].valid) begin
                    ent_d[res_tag].resolved   = 1'b1;
                    ent_d[res_tag].act_taken  = res_taken;
                    ent_d[res_tag].act_target = res_target;
                end

                if (alloc_fire) begin
                    ent_d[tail_q].valid       = 1'b1;
                    ent_d[tail_q].pc          = alloc_pc;
                    ent_d[tail_q].pred_taken  = alloc_pred_taken;
                    ent_d[tail_q].pred_target = alloc_pred_target;
                    ent_d[tail_q].resolved    = 1'b0;
                    ent_d[tail_q].act_taken   = 1'b0;
                    ent_d[tail_q].act_target  = '0;
                    tail_d = tail_q + TAG_W'(1);
                end

                if (retire) begin
                    ent_d[head_q].valid = 1'b0;
                    head_d    = head_q + TAG_W'(1);
                    upd_d     = 1'b1;
                    upd_pc_d  = head_e.pc;
                    upd_tk_d  = head_e.act_taken;
                    upd_tgt_d = head_e.act_target;
                end

                unique case ({alloc_fire, retire})
                    2'b10:   count_d = count_q + (TAG_W+1)'(1);
                    2'b01:   count_d = count_q - (TAG_W+1)'(1);
                    default: count_d = count_q;
                endcase

                // Younger entries are dropped right away so they can never
                // retire; the FLUSH cycle then blocks new work for one cycle.
                if (retire && mispredict) begin
                    for (int i = 0; i < DEPTH; i++) begin
                        ent_d[i] = '0;
                    end
                    head_d  = '0;
                    tail_d  = '0;
                    count_d = '0;
                    state_d = ST_FLUSH;
                    redir_d = 1'b1;
                    flush_d = 1'b1;
                    rpc_d   = head_e.act_taken ? head_e.act_target
                                               : head_e.pc + INSN_SIZE;
                end
            end

            ST_FLUSH: begin
                for (int i = 0; i < DEPTH; i++) begin
                    ent_d[i] = '0;
                end
                head_d  = '0;
                tail_d  = '0;
                count_d = '0;
                state_d = ST_RUN;
            end

            default: state_d = ST_RUN;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                ent_q[i] <= '0;
            end
            head_q    <= '0;
            tail_q    <= '0;
            count_q   <= '0;
            state_q   <= ST_RUN;
            upd_q     <= 1'b0;
            upd_pc_q  <= '0;
            upd_tk_q  <= 1'b0;
            upd_tgt_q <= '0;
            redir_q   <= 1'b0;
            rpc_q     <= '0;
            flush_q   <= 1'b0;
        end else begin
            ent_q     <= ent_d;
            head_q    <= head_d;
            tail_q    <= tail_d;
            count_q   <= count_d;
            state_q   <= state_d;
            upd_q     <= upd_d;
            upd_pc_q  <= upd_pc_d;
            upd_tk_q  <= upd_tk_d;
            upd_tgt_q <= upd_tgt_d;
            redir_q   <= redir_d;
            rpc_q     <= rpc_d;
            flush_q   <= flush_d;
        end
    end

    assign update        = upd_q;
    assign update_pc     = upd_pc_q;
    assign update_taken  = upd_tk_q;
    assign update_target = upd_tgt_q;
    assign redirect      = redir_q;
    assign redirect_pc   = rpc_q;
    assign flush         = flush_q;

endmodule

// File: tb/tb_branch_resolver.sv
// Self-checking bench for branch_resolver: in-order reference model feeds a
// scoreboard of expected retires; directed checks cover ready/count/reset.
module tb_branch_resolver;

    localparam int DEPTH = 8;
    localparam int TAG_W = 3;

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic             alloc_valid = 1'b0;
    logic [31:0]      alloc_pc = '0;
    logic             alloc_pred_taken = 1'b0;
    logic [31:0]      alloc_pred_target = '0;
    logic             alloc_ready;
    logic [TAG_W-1:0] alloc_tag;
    logic             res_valid = 1'b0;
    logic [TAG_W-1:0] res_tag = '0;
    logic             res_taken = 1'b0;
    logic [31:0]      res_target = '0;
    logic             update;
    logic [31:0]      update_pc;
    logic             update_taken;
    logic [31:0]      update_target;
    logic             redirect;
    logic [31:0]      redirect_pc;
    logic             flush;
    logic [TAG_W:0]   count;

    branch_resolver #(.DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst),
        .alloc_valid(alloc_valid), .alloc_pc(alloc_pc),
        .alloc_pred_taken(alloc_pred_taken),
        .alloc_pred_target(alloc_pred_target),
        .alloc_ready(alloc_ready), .alloc_tag(alloc_tag),
        .res_valid(res_valid), .res_tag(res_tag),
        .res_taken(res_taken), .res_target(res_target),
        .update(update), .update_pc(update_pc),
        .update_taken(update_taken), .update_target(update_target),
        .redirect(redirect), .redirect_pc(redirect_pc),
        .flush(flush), .count(count)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    typedef struct {
        logic [31:0] pc;
        logic        tk;
        logic [31:0] tgt;
        logic        mis;
        logic [31:0] rpc;
    } exp_t;

    exp_t sb[$];

    logic [31:0] m_pc  [DEPTH];
    logic [31:0] m_ptg [DEPTH];
    logic [31:0] m_atg [DEPTH];
    logic        m_pt  [DEPTH];
    logic        m_at  [DEPTH];
    logic        m_v   [DEPTH];
    logic        m_r   [DEPTH];
    int          m_head = 0;
    int          m_tail = 0;

    task automatic m_clear();
        for (int i = 0; i < DEPTH; i++) begin
            m_v[i] = 1'b0;
            m_r[i] = 1'b0;
        end
        m_head = 0;
        m_tail = 0;
    endtask

    task automatic m_alloc(input logic [31:0] pc, input logic pt,
                           input logic [31:0] ptg);
        m_v[m_tail]   = 1'b1;
        m_r[m_tail]   = 1'b0;
        m_pc[m_tail]  = pc;
        m_pt[m_tail]  = pt;
        m_ptg[m_tail] = ptg;
        m_tail = (m_tail + 1) % DEPTH;
    endtask

    // Resolve in the model, then retire everything now retirable in order.
    task automatic m_resolve(input int tag, input logic tk,
                             input logic [31:0] tgt);
        exp_t e;
        if (m_v[tag]) begin
            m_r[tag]   = 1'b1;
            m_at[tag]  = tk;
            m_atg[tag] = tgt;
        end
        while (m_v[m_head] && m_r[m_head]) begin
            e.pc  = m_pc[m_head];
            e.tk  = m_at[m_head];
            e.tgt = m_atg[m_head];
            e.mis = (m_pt[m_head] != m_at[m_head]) ||
                    (m_pt[m_head] && m_at[m_head] &&
                     m_ptg[m_head] != m_atg[m_head]);
            e.rpc = m_at[m_head] ? m_atg[m_head] : m_pc[m_head] + 32'd4;
            sb.push_back(e);
            m_v[m_head] = 1'b0;
            m_head = (m_head + 1) % DEPTH;
            if (e.mis) begin
                m_clear();
                break;
            end
        end
    endtask

    task automatic tick(input int n = 1);
        for (int i = 0; i < n; i++) @(negedge clk);
    endtask

    task automatic do_alloc(input logic [31:0] pc, input logic pt,
                            input logic [31:0] ptg);
        alloc_valid       = 1'b1;
        alloc_pc          = pc;
        alloc_pred_taken  = pt;
        alloc_pred_target = ptg;
        check("alloc_ready", alloc_ready, 1);
        check("alloc_tag", alloc_tag, m_tail);
        m_alloc(pc, pt, ptg);
        tick();
        alloc_valid = 1'b0;
    endtask

    task automatic do_res(input int tag, input logic tk,
                          input logic [31:0] tgt);
        res_valid  = 1'b1;
        res_tag    = TAG_W'(tag);
        res_taken  = tk;
        res_target = tgt;
        m_resolve(tag, tk, tgt);
        tick();
        res_valid = 1'b0;
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (rst && update) begin
            if (sb.size() == 0) begin
                check("unexp_update", update_pc, 32'hFFFF_FFFF);
            end else begin
                e = sb.pop_front();
                check("upd_pc", update_pc, e.pc);
                check("upd_taken", update_taken, e.tk);
                check("upd_target", update_target, e.tgt);
                check("upd_redirect", redirect, e.mis);
                check("upd_flush", flush, e.mis);
                if (e.mis) check("redirect_pc", redirect_pc, e.rpc);
            end
        end
        if (rst && !update && (redirect || flush)) begin
            check("stray_pulse", {redirect, flush}, 0);
        end
    end

    initial begin
        int base;
        m_clear();

        tick();
        check("rst_update", update, 0);
        check("rst_redirect", redirect, 0);
        check("rst_flush", flush, 0);
        check("rst_count", count, 0);
        check("rst_tag", alloc_tag, 0);
        check("rst_upd_pc", update_pc, 0);
        check("rst_rpc", redirect_pc, 0);
        rst = 1'b1;
        tick();
        check("rel_ready", alloc_ready, 1);

        // Correctly predicted not-taken branch.
        do_alloc(32'h100, 1'b0, 32'h0);
        do_res(0, 1'b0, 32'h0);
        tick();
        check("t1_count", count, 0);

        // Taken with wrong target: redirect/flush, one blocked cycle.
        do_alloc(32'h200, 1'b1, 32'h240);
        do_res(1, 1'b1, 32'h280);
        check("misp_ready", alloc_ready, 0);
        tick();
        check("flush_ready", alloc_ready, 0);
        check("flush_count", count, 0);
        tick();
        check("post_ready", alloc_ready, 1);
        check("post_tag", alloc_tag, 0);

        // Fill, then pop one while an alloc is held pending.
        for (int i = 0; i < DEPTH; i++) begin
            do_alloc(32'h1000 + 32'(i * 4), 1'b0, 32'h0);
        end
        check("full_count", count, DEPTH);
        alloc_valid       = 1'b1;
        alloc_pc          = 32'h2000;
        alloc_pred_taken  = 1'b0;
        alloc_pred_target = 32'h0;
        check("full_ready", alloc_ready, 0);
        do_res(0, 1'b0, 32'h1004);
        alloc_valid = 1'b1;
        check("retire_full_ready", alloc_ready, 0);
        tick();
        check("pop_ready", alloc_ready, 1);
        check("wrap_tag", alloc_tag, 0);
        m_alloc(32'h2000, 1'b0, 32'h0);
        tick();
        alloc_valid = 1'b0;
        check("refill_count", count, DEPTH);
        for (int i = 1; i <= DEPTH; i++) begin
            do_res(i % DEPTH, 1'b0, 32'h0);
        end
        tick(4);
        check("drain_count", count, 0);

        // Out-of-order resolves retire in program order.
        base = m_tail;
        do_alloc(32'h300, 1'b0, 32'h0);
        do_alloc(32'h304, 1'b1, 32'h400);
        do_alloc(32'h308, 1'b0, 32'h0);
        do_res((base + 2) % DEPTH, 1'b0, 32'h0);
        do_res(base, 1'b0, 32'h0);
        do_res((base + 1) % DEPTH, 1'b1, 32'h400);
        tick(4);
        check("ooo_count", count, 0);

        // Mispredicted head with two resolved younger entries.
        base = m_tail;
        do_alloc(32'h500, 1'b0, 32'h0);
        do_alloc(32'h504, 1'b0, 32'h0);
        do_alloc(32'h508, 1'b0, 32'h0);
        do_res((base + 1) % DEPTH, 1'b0, 32'h0);
        do_res((base + 2) % DEPTH, 1'b0, 32'h0);
        do_res(base, 1'b1, 32'h5000);
        tick(4);
        check("squash_count", count, 0);
        check("squash_tag", alloc_tag, 0);

        // Fall-through wrap, then reset dropped during FLUSH.
        do_alloc(32'hFFFF_FFFC, 1'b1, 32'h40);
        do_res(0, 1'b0, 32'h0);
        tick();
        #2;
        rst = 1'b0;
        #1;
        check("mid_update", update, 0);
        check("mid_redirect", redirect, 0);
        check("mid_flush", flush, 0);
        check("mid_rpc", redirect_pc, 0);
        check("mid_upd_pc", update_pc, 0);
        check("mid_count", count, 0);
        tick();
        rst = 1'b1;
        m_clear();
        tick();
        check("rerel_ready", alloc_ready, 1);

        for (int i = 0; i < 50 && sb.size() != 0; i++) tick();
        check("sb_empty", sb.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
